// File: rtl/ipc_doorbell_queue.sv
// Doorbell FIFO: a toggle on the Nios PIO MSB queues the payload and raises irq_o toward the HPS.
// Define DOORBELL_IRQ_GAP_EN to drop irq_o for one cycle between back-to-back messages.
module ipc_doorbell_queue #(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 9
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    input  logic [PAYLOAD_W:0]     pio_in,
    input  logic                   ack_i,
    input  logic                   ovf_clr_i,
    output logic                   irq_o,
    output logic [PAYLOAD_W-1:0]   msg_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_ASSERT,
        IRQ_GAP
    } irq_state_t;

    logic [PAYLOAD_W:0]   sample_reg;
    logic                 sample_valid_reg;
    logic                 hist_msb_reg;
    logic                 hist_valid_reg;
    logic [PAYLOAD_W-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr_reg;
    logic [AW-1:0]        rd_ptr_reg;
    logic [CW-1:0]        count_reg;
    logic [CW-1:0]        count_next;
    logic                 overflow_reg;
    logic                 overflow_next;
    irq_state_t           irq_state_reg;
    irq_state_t           irq_state_next;

    logic ring;
    logic pop;
    logic full;
    logic wr_en;
    logic ovf_event;

    // The first sample after reset only seeds the history, so no ring is seen then.
    assign ring      = sample_valid_reg && hist_valid_reg && (sample_reg[PAYLOAD_W] != hist_msb_reg);
    assign pop       = ack_i && (count_reg != '0);
    assign full      = (count_reg == FULL_COUNT);
    assign wr_en     = ring && (!full || pop);
    assign ovf_event = ring && full && !pop;

    always_comb begin
        count_next = count_reg;
        case ({wr_en, pop})
            2'b10:   count_next = count_reg + COUNT_ONE;
            2'b01:   count_next = count_reg - COUNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    // A fresh overflow takes priority over a clear arriving in the same cycle.
    always_comb begin
        overflow_next = overflow_reg;
        if (ovf_event) begin
            overflow_next = 1'b1;
        end else if (ovf_clr_i) begin
            overflow_next = 1'b0;
        end
    end

    always_comb begin
        irq_state_next = irq_state_reg;
`ifdef DOORBELL_IRQ_GAP_EN
        case (irq_state_reg)
            IRQ_IDLE: begin
                if (count_next != '0) irq_state_next = IRQ_ASSERT;
            end
            IRQ_ASSERT: begin
                if (pop) irq_state_next = (count_next == '0) ? IRQ_IDLE : IRQ_GAP;
            end
            IRQ_GAP: begin
                irq_state_next = (count_next != '0) ? IRQ_ASSERT : IRQ_IDLE;
            end
            default: irq_state_next = IRQ_IDLE;
        endcase
`else
        irq_state_next = (count_next != '0) ? IRQ_ASSERT : IRQ_IDLE;
`endif
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sample_reg       <= '0;
            sample_valid_reg <= 1'b0;
            hist_msb_reg     <= 1'b0;
            hist_valid_reg   <= 1'b0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            overflow_reg     <= 1'b0;
            irq_state_reg    <= IRQ_IDLE;
        end else begin
            sample_reg       <= pio_in;
            sample_valid_reg <= 1'b1;
            hist_msb_reg     <= sample_reg[PAYLOAD_W];
            hist_valid_reg   <= sample_valid_reg;
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)   rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            count_reg        <= count_next;
            overflow_reg     <= overflow_next;
            irq_state_reg    <= irq_state_next;
        end
    end

    // Storage needs no reset: entries are only visible while count_reg covers them.
    always_ff @(posedge clk_clk) begin
        if (wr_en) mem[wr_ptr_reg] <= sample_reg[PAYLOAD_W-1:0];
    end

    assign msg_o      = (count_reg != '0) ? mem[rd_ptr_reg] : '0;
    assign count_o    = count_reg;
    assign overflow_o = overflow_reg;
    assign irq_o      = (irq_state_reg == IRQ_ASSERT);

endmodule

// File: tb/tb_ipc_doorbell_queue.sv
// Bench for ipc_doorbell_queue: directed scenarios plus random traffic against a queue-based model.
module tb_ipc_doorbell_queue;

    localparam int DEPTH = 4;
    localparam int PW    = 9;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [PW:0]   pio;
    logic          ack;
    logic          ovf_clr;
    logic          irq;
    logic [PW-1:0] msg;
    logic [CW-1:0] count;
    logic          ovf;

    int n_tests = 0;
    int n_fail  = 0;

    ipc_doorbell_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .pio_in        (pio),
        .ack_i         (ack),
        .ovf_clr_i     (ovf_clr),
        .irq_o         (irq),
        .msg_o         (msg),
        .count_o       (count),
        .overflow_o    (ovf)
    );

    always #5 clk = ~clk;

    // Reference model: payload queue, sticky flag, irq level, and the last two PIO samples.
    logic [PW-1:0] mq[$];
    logic          m_ovf;
    logic          m_irq;
    logic          smp_msb;
    logic          smp_valid;
    logic [PW-1:0] smp_pay;
    logic          hist_msb;
    logic          hist_valid;

    task automatic model_reset();
        mq.delete();
        m_ovf      = 1'b0;
        m_irq      = 1'b0;
        smp_msb    = 1'b0;
        smp_valid  = 1'b0;
        smp_pay    = '0;
        hist_msb   = 1'b0;
        hist_valid = 1'b0;
    endtask

    task automatic model_step();
        logic push;
        logic pop;
        logic ovf_ev;
        logic was_irq;
        push    = hist_valid && smp_valid && (smp_msb != hist_msb);
        pop     = ack && (mq.size() != 0);
        ovf_ev  = 1'b0;
        was_irq = m_irq;
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(smp_pay);
            else ovf_ev = 1'b1;
        end
        m_ovf = ovf_ev ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
`ifdef DOORBELL_IRQ_GAP_EN
        m_irq = (mq.size() != 0) && !(was_irq && pop);
`else
        m_irq = (mq.size() != 0);
`endif
        hist_msb   = smp_msb;
        hist_valid = smp_valid;
        smp_msb    = pio[PW];
        smp_pay    = pio[PW-1:0];
        smp_valid  = 1'b1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [31:0] exp_msg;
        exp_msg = (mq.size() != 0) ? 32'(mq[0]) : 32'd0;
        check("count", 32'(count), 32'(mq.size()));
        check("msg", 32'(msg), exp_msg);
        check("overflow", 32'(ovf), 32'(m_ovf));
        check("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic ring(input logic [PW-1:0] p);
        pio = {~pio[PW], p};
        tick();
    endtask

    task automatic pop_one();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_msg"}, 32'(msg), 32'd0);
        check({tag, "_ovf"}, 32'(ovf), 32'd0);
        check({tag, "_irq"}, 32'(irq), 32'd0);
    endtask

    int exp029[4] = '{2, 3, 4, 7};

    initial begin
        rst_n   = 1'b0;
        pio     = '0;
        ack     = 1'b0;
        ovf_clr = 1'b0;
        model_reset();
        repeat (2) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (3) tick();

        // Single ring
        ring(9'h0A5);
        check("ring_irq_edge1", 32'(irq), 32'd0);
        tick();
        check("ring_irq_edge2", 32'(irq), 32'd1);
        check("ring_msg", 32'(msg), 32'h0A5);
        check("ring_count", 32'(count), 32'd1);
        $display("[TB] single ring msg=0x%0h count=%0d irq=%0d", msg, count, irq);
        pop_one();
        check("ack_irq", 32'(irq), 32'd0);
        check("ack_count", 32'(count), 32'd0);

        // Overflow: five rings into four entries
        for (int i = 1; i <= 5; i++) ring(PW'(i));
        tick();
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_flag", 32'(ovf), 32'd1);
        $display("[TB] overflow count=%0d overflow=%0d", count, ovf);
        for (int i = 1; i <= 4; i++) begin
            check("ovf_pop_msg", 32'(msg), 32'(i));
            pop_one();
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clear", 32'(ovf), 32'd0);

        // Full with simultaneous push and pop
        for (int i = 1; i <= 4; i++) ring(PW'(i));
        tick();
        check("full_count", 32'(count), 32'd4);
        ring(9'd7);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("pushpop_count", 32'(count), 32'd4);
        check("pushpop_ovf", 32'(ovf), 32'd0);
        $display("[TB] full push+pop count=%0d overflow=%0d", count, ovf);
        for (int i = 0; i < 4; i++) begin
            check("pushpop_msg", 32'(msg), 32'(exp029[i]));
            pop_one();
        end

        // Back-to-back irq behaviour
        ring(9'h011);
        ring(9'h022);
        tick();
        check("gap_pre_irq", 32'(irq), 32'd1);
        pop_one();
`ifdef DOORBELL_IRQ_GAP_EN
        check("gap_low", 32'(irq), 32'd0);
`else
        check("gap_nogap_high", 32'(irq), 32'd1);
`endif
        tick();
        check("gap_after", 32'(irq), 32'd1);
        check("gap_msg", 32'(msg), 32'h022);
        $display("[TB] gap sequence irq=%0d msg=0x%0h", irq, msg);
        pop_one();
        check("gap_drain_irq", 32'(irq), 32'd0);

        // Reset with entries queued, then release with PIO MSB high
        ring(9'h031);
        ring(9'h032);
        ring(9'h033);
        tick();
        check("rst_pre_count", 32'(count), 32'd3);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        pio = {1'b1, 9'h155};
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("rst_release_count", 32'(count), 32'd0);
        check("rst_release_irq", 32'(irq), 32'd0);
        $display("[TB] reset release count=%0d irq=%0d", count, irq);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                compare_all();
                tick();
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 99) < 40) pio[PW] = ~pio[PW];
            if ($urandom_range(0, 99) < 60) pio[PW-1:0] = PW'($urandom);
            ack     = ($urandom_range(0, 99) < 30);
            ovf_clr = ($urandom_range(0, 99) < 5);
            tick();
        end
        ack     = 1'b0;
        ovf_clr = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
